wash_seq_ctrl: RTL and testbench

- Parametrised washing-machine programme sequencer: successor to the fixed single-phase countdown controller.
- Runs a mode-selected sequence of fill / wash / drain / rinse (N cycles) / spin phases on a 1-second tick, and drives the water valves and motor.
- Supports pause/resume on the start button and exposes total remaining seconds for the 7-segment scanner.
- Sits between the button debouncer (consumes its one-cycle pulse) and the display/LED drivers.

---
 rtl/wash_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_wash_seq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wash_seq_ctrl
// Purpose  : Washing-machine programme sequencer. Runs a mode-selected
//            sequence of fill / wash / drain / rinse (N cycles) / spin phases
//            on a 1-second tick derived from clk, drives the water valves and
//            drum motor, supports pause/resume on the start pulse and reports
//            the total programme seconds still to run.
// Ports    : clk        in   system clock
//            rst        in   asynchronous active-low reset
//            on         in   power enable, low forces IDLE synchronously
//            start_p    in   debounced one-cycle start/pause pulse
//            mode       in   2  programme select (00 spin, 01 rinse+spin,
//                            10 wash+rinse+spin, 11 wash+extra rinse+spin)
//            water_in   out  fill valve
//            water_out  out  drain valve
//            motor_on   out  drum motor
//            phase_led  out  8  status LEDs (2 idle, 3 wash, 4 rinse,
//                            5 spin, 6 done, 7 paused)
//            remain_s   out  CNT_W  total programme seconds remaining
//            done       out  high in DONE
// Revision : 1.0 - initial release
// ============================================================================
module wash_seq_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int FILL_S   = 10,
  parameter int WASH_S   = 30,
  parameter int DRAIN_S  = 8,
  parameter int RINSE_S  = 20,
  parameter int SPIN_S   = 15,
  parameter int RINSE_N  = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             start_p,
  input  logic [1:0]       mode,
  output logic             water_in,
  output logic             water_out,
  output logic             motor_on,
  output logic [7:0]       phase_led,
  output logic [CNT_W-1:0] remain_s,
  output logic             done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Rinse index must be able to hold RINSE_N+1 without wrapping.
  localparam int RI_W = $clog2(RINSE_N + 2);
  localparam int WC_S = FILL_S + WASH_S + DRAIN_S;
  localparam int RC_S = FILL_S + RINSE_S + DRAIN_S;

  localparam logic [CNT_W-1:0] TOT_00 = CNT_W'(SPIN_S);
  localparam logic [CNT_W-1:0] TOT_01 = CNT_W'(RINSE_N * RC_S + SPIN_S);
  localparam logic [CNT_W-1:0] TOT_10 = CNT_W'(WC_S + RINSE_N * RC_S + SPIN_S);
  localparam logic [CNT_W-1:0] TOT_11 = CNT_W'(WC_S + (RINSE_N + 1) * RC_S + SPIN_S);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [RI_W-1:0]  RINSE_STD = RI_W'(RINSE_N);
  localparam logic [RI_W-1:0]  RINSE_EXT = RI_W'(RINSE_N + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_FILL  = 4'd1,
    S_W_WASH  = 4'd2,
    S_W_DRAIN = 4'd3,
    S_R_FILL  = 4'd4,
    S_R_AGIT  = 4'd5,
    S_R_DRAIN = 4'd6,
    S_SPIN    = 4'd7,
    S_PAUSED  = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t           state;
  state_t           saved;
  state_t           adv_state;
  state_t           first_state;
  logic [PS_W-1:0]  presc;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] prog_total;
  logic [RI_W-1:0]  rinse_idx;
  logic [RI_W-1:0]  rinse_tgt;
  logic [1:0]       mode_q;
  logic             tick;
  logic             rinse_last;

  // Phase duration loaded on entry; non-timed states get zero.
  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      S_W_FILL, S_R_FILL:   phase_len = CNT_W'(FILL_S);
      S_W_WASH:             phase_len = CNT_W'(WASH_S);
      S_W_DRAIN, S_R_DRAIN: phase_len = CNT_W'(DRAIN_S);
      S_R_AGIT:             phase_len = CNT_W'(RINSE_S);
      S_SPIN:               phase_len = CNT_W'(SPIN_S);
      default:              phase_len = '0;
    endcase
  endfunction

  // Output image of a state: {water_in, water_out, motor_on, done, phase_led}.
  function automatic logic [11:0] out_vec(input state_t s);
    case (s)
      S_W_FILL:  out_vec = {4'b1000, 8'h08};
      S_W_WASH:  out_vec = {4'b0010, 8'h08};
      S_W_DRAIN: out_vec = {4'b0100, 8'h08};
      S_R_FILL:  out_vec = {4'b1000, 8'h10};
      S_R_AGIT:  out_vec = {4'b0010, 8'h10};
      S_R_DRAIN: out_vec = {4'b0100, 8'h10};
      S_SPIN:    out_vec = {4'b0110, 8'h20};
      S_DONE:    out_vec = {4'b0001, 8'h40};
      S_PAUSED:  out_vec = {4'b0000, 8'h80};
      default:   out_vec = {4'b0000, 8'h04};
    endcase
  endfunction

  // Successor of a timed phase once its timer runs out.
  function automatic state_t next_phase(input state_t s, input logic last);
    case (s)
      S_W_FILL:  next_phase = S_W_WASH;
      S_W_WASH:  next_phase = S_W_DRAIN;
      S_W_DRAIN: next_phase = S_R_FILL;
      S_R_FILL:  next_phase = S_R_AGIT;
      S_R_AGIT:  next_phase = S_R_DRAIN;
      S_R_DRAIN: next_phase = last ? S_SPIN : S_R_FILL;
      S_SPIN:    next_phase = S_DONE;
      default:   next_phase = S_IDLE;
    endcase
  endfunction

  always_comb begin
    case (mode)
      2'b00:   begin prog_total = TOT_00; first_state = S_SPIN;   end
      2'b01:   begin prog_total = TOT_01; first_state = S_R_FILL; end
      2'b10:   begin prog_total = TOT_10; first_state = S_W_FILL; end
      default: begin prog_total = TOT_11; first_state = S_W_FILL; end
    endcase
  end

  assign tick       = (presc == PS_LAST);
  assign rinse_tgt  = (mode_q == 2'b11) ? RINSE_EXT : RINSE_STD;
  // Evaluated in R_DRAIN, before the index is bumped for the cycle just ended.
  assign rinse_last = ((rinse_idx + RI_W'(1)) >= rinse_tgt);
  assign adv_state  = next_phase(state, rinse_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      saved     <= S_IDLE;
      presc     <= '0;
      timer     <= '0;
      rinse_idx <= '0;
      mode_q    <= '0;
      remain_s  <= '0;
      {water_in, water_out, motor_on, done, phase_led} <= out_vec(S_IDLE);
    end else if (!on) begin
      state     <= S_IDLE;
      saved     <= S_IDLE;
      presc     <= '0;
      timer     <= '0;
      rinse_idx <= '0;
      mode_q    <= '0;
      remain_s  <= '0;
      {water_in, water_out, motor_on, done, phase_led} <= out_vec(S_IDLE);
    end else begin
      case (state)
        S_IDLE: begin
          if (start_p) begin
            mode_q    <= mode;
            remain_s  <= prog_total;
            rinse_idx <= '0;
            presc     <= '0;
            state     <= first_state;
            timer     <= phase_len(first_state);
            {water_in, water_out, motor_on, done, phase_led} <= out_vec(first_state);
          end
        end
        S_PAUSED: begin
          // Timer, remain_s and rinse index were frozen; only the
          // prescaler restarts so the current second begins afresh.
          if (start_p) begin
            state <= saved;
            presc <= '0;
            {water_in, water_out, motor_on, done, phase_led} <= out_vec(saved);
          end
        end
        S_DONE: begin
          if (start_p) begin
            state    <= S_IDLE;
            remain_s <= '0;
            {water_in, water_out, motor_on, done, phase_led} <= out_vec(S_IDLE);
          end
        end
        default: begin
          if (start_p) begin
            // Pause takes priority over a coincident tick.
            saved <= state;
            state <= S_PAUSED;
            presc <= '0;
            {water_in, water_out, motor_on, done, phase_led} <= out_vec(S_PAUSED);
          end else if (tick) begin
            presc <= '0;
            if (remain_s != '0) begin
              remain_s <= remain_s - CNT_W'(1);
            end
            if (timer == CNT_W'(1)) begin
              state <= adv_state;
              timer <= phase_len(adv_state);
              {water_in, water_out, motor_on, done, phase_led} <= out_vec(adv_state);
              if (state == S_R_DRAIN) begin
                rinse_idx <= rinse_idx + RI_W'(1);
              end
              if (adv_state == S_DONE) begin
                remain_s <= '0;
              end
            end else begin
              timer <= timer - CNT_W'(1);
            end
          end else begin
            presc <= presc + PS_W'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wash_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_seq_ctrl
// Purpose  : Self-checking bench for wash_seq_ctrl. A phase-list model
//            (programme built as a queue of {kind, led group, seconds})
//            predicts every output each cycle; directed scenarios pin the
//            model with hand-computed totals and durations, then a
//            randomized phase exercises start/pause/mode/power.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int FILL_S   = 2;
  localparam int WASH_S   = 3;
  localparam int DRAIN_S  = 2;
  localparam int RINSE_S  = 2;
  localparam int SPIN_S   = 3;
  localparam int RINSE_N  = 1;
  localparam int CNT_W    = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             on = 1'b0;
  logic             start_p = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             water_in;
  logic             water_out;
  logic             motor_on;
  logic [7:0]       phase_led;
  logic [CNT_W-1:0] remain_s;
  logic             done;

  wash_seq_ctrl #(
    .TICK_DIV(TICK_DIV), .FILL_S(FILL_S), .WASH_S(WASH_S), .DRAIN_S(DRAIN_S),
    .RINSE_S(RINSE_S), .SPIN_S(SPIN_S), .RINSE_N(RINSE_N), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .on(on), .start_p(start_p), .mode(mode),
    .water_in(water_in), .water_out(water_out), .motor_on(motor_on),
    .phase_led(phase_led), .remain_s(remain_s), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // kind: 0 fill, 1 agitate, 2 drain, 3 spin; grp = LED bit index
  typedef struct {
    int kind;
    int grp;
    int dur;
  } ph_t;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  ph_t prog[$];
  int  m_st = M_IDLE;
  int  m_idx = 0;
  int  m_secs = 0;
  int  m_sub = 0;
  int  m_remain = 0;

  function automatic ph_t mk(input int k, input int g, input int d);
    ph_t p;
    p.kind = k;
    p.grp  = g;
    p.dur  = d;
    return p;
  endfunction

  function automatic void build(input logic [1:0] md);
    int nr;
    prog.delete();
    if (md != 2'b00) begin
      if (md[1]) begin
        prog.push_back(mk(0, 3, FILL_S));
        prog.push_back(mk(1, 3, WASH_S));
        prog.push_back(mk(2, 3, DRAIN_S));
      end
      nr = RINSE_N + ((md == 2'b11) ? 1 : 0);
      for (int i = 0; i < nr; i++) begin
        prog.push_back(mk(0, 4, FILL_S));
        prog.push_back(mk(1, 4, RINSE_S));
        prog.push_back(mk(2, 4, DRAIN_S));
      end
    end
    prog.push_back(mk(3, 5, SPIN_S));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || !on) begin
      m_st     = M_IDLE;
      m_remain = 0;
      m_sub    = 0;
    end else begin
      case (m_st)
        M_IDLE: if (start_p) begin
          build(mode);
          m_idx    = 0;
          m_secs   = prog[0].dur;
          m_sub    = 0;
          m_remain = 0;
          foreach (prog[i]) m_remain += prog[i].dur;
          m_st     = M_RUN;
        end
        M_PAUSE: if (start_p) begin
          m_st  = M_RUN;
          m_sub = 0;
        end
        M_DONE: if (start_p) begin
          m_st     = M_IDLE;
          m_remain = 0;
        end
        default: begin
          if (start_p) begin
            m_st  = M_PAUSE;
            m_sub = 0;
          end else begin
            m_sub++;
            if (m_sub == TICK_DIV) begin
              m_sub = 0;
              if (m_remain > 0) m_remain--;
              m_secs--;
              if (m_secs == 0) begin
                m_idx++;
                if (m_idx == prog.size()) begin
                  m_st     = M_DONE;
                  m_remain = 0;
                end else begin
                  m_secs = prog[m_idx].dur;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // {water_in, water_out, motor_on, done, phase_led}
  function automatic logic [11:0] exp_out();
    logic [11:0] v;
    v = '0;
    case (m_st)
      M_IDLE:  v[7:0] = 8'h04;
      M_PAUSE: v[7:0] = 8'h80;
      M_DONE:  begin v[8] = 1'b1; v[7:0] = 8'h40; end
      default: begin
        v[7:0] = 8'(1 << prog[m_idx].grp);
        case (prog[m_idx].kind)
          0:       v[11] = 1'b1;
          1:       v[9] = 1'b1;
          2:       v[10] = 1'b1;
          default: begin v[10] = 1'b1; v[9] = 1'b1; end
        endcase
      end
    endcase
    return v;
  endfunction

  logic [11:0] ev;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = exp_out();
      check("water_in",  32'(water_in),  32'(ev[11]));
      check("water_out", 32'(water_out), 32'(ev[10]));
      check("motor_on",  32'(motor_on),  32'(ev[9]));
      check("done",      32'(done),      32'(ev[8]));
      check("phase_led", 32'(phase_led), 32'(ev[7:0]));
      check("remain_s",  32'(remain_s),  32'(m_remain));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic pulse_start();
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_done", 32'(done), 32'd1);
  endtask

  task automatic run_prog(input logic [1:0] md, input int tot, input int cyc,
                          input int wi, input int mo, input int wo);
    int n = 0;
    int cwi = 0;
    int cmo = 0;
    int cwo = 0;
    mode = md;
    pulse_start();
    check("prog_total",  32'(remain_s), 32'(tot));
    check("model_total", 32'(m_remain), 32'(tot));
    while (!done && n < 500) begin
      cwi += int'(water_in);
      cmo += int'(motor_on);
      cwo += int'(water_out);
      @(negedge clk);
      n++;
    end
    check("prog_cycles",      32'(n),   32'(cyc));
    check("water_in_cycles",  32'(cwi), 32'(wi));
    check("motor_cycles",     32'(cmo), 32'(mo));
    check("water_out_cycles", 32'(cwo), 32'(wo));
    check("done_led",         32'(phase_led), 32'h40);
    pulse_start();
    check("done_to_idle_led", 32'(phase_led), 32'h04);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_led",    32'(phase_led), 32'h04);
    check("reset_remain", 32'(remain_s), 32'd0);
    check("reset_act",    32'({water_in, water_out, motor_on, done}), 32'd0);
    rst = 1'b1;
    on  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Full programmes with hand-computed totals and actuator on-times.
    run_prog(2'b10, 16, 64, 16, 32, 28);
    run_prog(2'b00,  3, 12,  0, 12, 12);
    run_prog(2'b11, 22, 88, 24, 40, 36);
    run_prog(2'b01,  9, 36,  8, 20, 20);

    // Async reset during W_WASH.
    mode = 2'b10;
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led",    32'(phase_led), 32'h04);
    check("async_rst_remain", 32'(remain_s), 32'd0);
    check("async_rst_act",    32'({water_in, water_out, motor_on, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_idle", 32'(phase_led), 32'h04);

    // Pause in W_WASH after one tick; mode changes are ignored meanwhile.
    mode = 2'b10;
    pulse_start();
    mode = 2'b00;
    repeat (12) @(negedge clk);
    check("pre_pause_remain", 32'(remain_s), 32'd13);
    pulse_start();
    check("pause_led", 32'(phase_led), 32'h80);
    check("pause_act", 32'({water_in, water_out, motor_on}), 32'd0);
    repeat (50) @(negedge clk);
    check("pause_hold_remain", 32'(remain_s), 32'd13);
    pulse_start();
    n = 0;
    while (motor_on && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resume_wash_cycles", 32'(n), 32'd8);
    wait_done(n);
    pulse_start();

    // Pause on the same edge as a tick: tick discarded.
    mode = 2'b00;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    check("tick_pause_led",    32'(phase_led), 32'h80);
    check("tick_pause_remain", 32'(remain_s), 32'd3);
    pulse_start();
    wait_done(n);
    check("resume_spin_cycles", 32'(n), 32'd12);
    pulse_start();

    // Power drop during R_FILL, and start ignored while off.
    mode = 2'b01;
    pulse_start();
    repeat (3) @(negedge clk);
    on = 1'b0;
    @(negedge clk);
    check("off_led",    32'(phase_led), 32'h04);
    check("off_remain", 32'(remain_s), 32'd0);
    check("off_act",    32'({water_in, water_out, motor_on, done}), 32'd0);
    pulse_start();
    check("off_start_ignored", 32'(phase_led), 32'h04);
    on = 1'b1;
    @(negedge clk);

    // Randomized start/pause, mode wiggle and brief power drops.
    for (int i = 0; i < 4000; i++) begin
      start_p = ($urandom_range(0, 24) == 0);
      mode    = 2'($urandom_range(0, 3));
      on      = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    start_p = 1'b0;
    on      = 1'b1;
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
